ppm_decoder: RTL
================

// Module: ppm_decoder
// PURPOSE
//  Receive side of the 8-bit pulse-position link: recovers a pulse's position within a 256-cycle frame.
//  Samples an async PPM line plus a frame-sync line, timestamps the pulse rising edge against a local frame counter.
//  Publishes the decoded 8-bit position with a valid strobe and per-frame error flags. Tiny Tapeout top-level pinout.
// PARAMETERS
//  W            8   frame counter / position width (must be 8: output is uo_out[7:0])
//  SYNC_STAGES  2   flops per input synchronizer (>=2)
//  LATENCY      3   cycles subtracted from the captured count (1 transmitter register + SYNC_STAGES)
// PORTS
//  clk      in   1  system clock, single domain
//  rst_n    in   1  asynchronous active-low reset
//  ena      in   1  design enable, always 1; ignored
//  ui_in    in   8  [0]=ppm_in (async), [1]=frame_sync (async, active-high), [7:2] unused
//  uo_out   out  8  last successfully decoded position
//  uio_in   in   8  unused
//  uio_out  out  8  [0]=valid (1-cycle strobe), [1]=err_missing, [2]=err_multi, [7:3]=0
//  uio_oe   out  8  constant 8'b0000_0111
// BEHAVIOUR
//  Reset: uo_out=0, uio_out=0, cnt=0, pulse_cnt=0, state=HUNT, all sync flops 0. Reset mid-frame discards the frame.
//  Inputs: each line passes SYNC_STAGES flops. rise = s & ~s_d (one extra flop holds s_d). Only rising edges count.
//  Frame counter cnt (W bits): sync_rise -> cnt<=0; else cnt<=cnt+1, wrapping 255->0.
//  Frame close event: sync_rise OR cnt==255. Both in the same cycle = one close.
//  pulse_cnt: 2-bit saturating (0,1,2=many), cleared on close. A ppm_rise evaluated in the close cycle belongs to the closing frame.
//  Capture: on the first ppm_rise of a frame, pos <= cnt - LATENCY (mod 256; e.g. cnt=2 -> 255).
//  FSM: HUNT -> TRACK on the first close after reset; the HUNT-closed partial frame publishes nothing and leaves flags untouched.
//   TRACK stays TRACK; only reset returns to HUNT.
//  Publish in TRACK at each close, registered (visible the cycle after close):
//   exactly 1 pulse: uo_out<=pos, valid=1 for one cycle, err_missing<=0, err_multi<=0
//   0 pulses: uo_out holds, valid=0, err_missing<=1, err_multi<=0
//   >=2 pulses: uo_out holds, valid=0, err_multi<=1, err_missing<=0; pos is the first pulse's, discarded
//  Error flags are per-frame status: they hold until the next close, not sticky.
//  ppm_in held high across frames yields no new rise, so that frame reports err_missing.
// CONFIGURATION
//  PPM_DEGLITCH_EN defined: a qualifier flop follows the synchronizer; the line counts as high only after 2 consecutive high samples.
//   A 1-cycle glitch is ignored. Effective subtraction becomes LATENCY+1, so decoded values are unchanged for clean pulses.
//  Undefined: no qualifier; a 1-cycle high counts as a pulse; subtraction is LATENCY.
// STRUCTURE
//  ppm_pkg: PPM_W=8, frame max 8'hFF, pulse_cnt encoding (PC_NONE/PC_ONE/PC_MANY), state enum {HUNT,TRACK},
//   uio bit indices (VALID_BIT=0, ERR_MISS_BIT=1, ERR_MULTI_BIT=2).
//  Sub-module ppm_in_sync (SYNC_STAGES synchronizer + edge-detect flop, output rise) is instantiated twice: ppm_in and frame_sync.
//   The optional deglitch lives inside ppm_in_sync.
//  Top: frame counter, pulse counter, capture register, FSM, output registers.
// TESTING (LATENCY=3, macro off unless noted)
//  1 Reset: assert rst_n=0 mid-frame -> uo_out=0x00, uio_out=0x00, uio_oe=0x07 immediately; first frame after release never sets valid.
//  2 Basic decode: sync pulse, one frame to leave HUNT, then ppm rise detected at cnt=45 -> uo_out=42, uio_out[0]=1 for exactly 1 cycle after close.
//  3 Missing: frame with no pulse -> uio_out=0x02, uo_out holds 42; next good frame at cnt=103 -> uo_out=100, err_missing clears.
//  4 Multi: rises at cnt=10 and 20 -> uio_out[2]=1, valid=0, uo_out unchanged.
//  5 Wrap/boundary: rise detected at cnt=2 -> uo_out=255. Rise detected at cnt=255 counts toward the closing frame.
//   sync_rise coincident with cnt==255 -> single publish.
//  6 PPM_DEGLITCH_EN: 1-cycle ppm high -> err_missing. 4-cycle pulse whose transmitter count is 42 -> uo_out=42 (same as macro off).

Source files
------------

// File: rtl/ppm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppm_pkg
// Purpose  : Shared widths, encodings and bit indices for the PPM receiver.
// Revision : 1.0 - initial release
// ============================================================================
package ppm_pkg;

    localparam int PPM_W = 8;
    localparam logic [PPM_W-1:0] FRAME_MAX = 8'hFF;

    typedef enum logic [1:0] {
        PC_NONE = 2'd0,
        PC_ONE  = 2'd1,
        PC_MANY = 2'd2
    } pulse_cnt_t;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int VALID_BIT     = 0;
    localparam int ERR_MISS_BIT  = 1;
    localparam int ERR_MULTI_BIT = 2;

    localparam logic [7:0] UIO_OE_MASK = 8'b0000_0111;

    // Saturating pulse tally: NONE -> ONE -> MANY -> MANY.
    function automatic pulse_cnt_t pc_bump(input pulse_cnt_t pc);
        pulse_cnt_t r;
        case (pc)
            PC_NONE: r = PC_ONE;
            PC_ONE:  r = PC_MANY;
            default: r = PC_MANY;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppm_in_sync.sv
`default_nettype none
// ============================================================================
// Module   : ppm_in_sync
// Purpose  : Multi-flop synchronizer with rising-edge detect and an optional
//            two-sample high qualifier (enabled through the DEGLITCH parameter).
// Revision : 1.0 - initial release
// ============================================================================
module ppm_in_sync
    import ppm_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit DEGLITCH    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_d_q;
    logic                   w_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    generate
        if (DEGLITCH) begin : g_deglitch
            logic qual_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    qual_q <= 1'b0;
                end else begin
                    qual_q <= sync_q[SYNC_STAGES-1];
                end
            end

            // High only once two consecutive synchronized samples agree.
            assign w_line = sync_q[SYNC_STAGES-1] & qual_q;
        end else begin : g_direct
            assign w_line = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_d_q <= 1'b0;
        end else begin
            line_d_q <= w_line;
        end
    end

    assign rise_o = w_line & ~line_d_q;

endmodule
`default_nettype wire

// File: rtl/ppm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ppm_decoder
// Purpose  : PPM receiver; timestamps pulse edges in a 256-cycle frame and
//            publishes position plus per-frame error flags. Option: PPM_DEGLITCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ppm_decoder
    import ppm_pkg::*;
#(
    parameter int W           = PPM_W,
    parameter int SYNC_STAGES = 2,
    parameter int LATENCY     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

`ifdef PPM_DEGLITCH_EN
    localparam bit DEGLITCH = 1'b1;
    localparam int SUBTRACT = LATENCY + 1;
`else
    localparam bit DEGLITCH = 1'b0;
    localparam int SUBTRACT = LATENCY;
`endif
    localparam logic [W-1:0] SUB_W = W'(SUBTRACT);

    logic         w_ppm_rise;
    logic         w_sync_rise;
    logic         w_close;
    logic         w_unused;

    state_t       state_q;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] pos_q, pos_d;
    pulse_cnt_t   pc_q, pc_d;
    logic [W-1:0] out_q;
    logic         valid_q;
    logic         err_miss_q;
    logic         err_multi_q;

    ppm_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEGLITCH    (DEGLITCH)
    ) u_ppm_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ui_in[0]),
        .rise_o  (w_ppm_rise)
    );

    ppm_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEGLITCH    (1'b0)
    ) u_frame_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ui_in[1]),
        .rise_o  (w_sync_rise)
    );

    // A rise seen in the close cycle is folded into the frame being closed.
    always_comb begin
        cnt_d   = w_sync_rise ? '0 : cnt_q + 1'b1;
        w_close = w_sync_rise | (cnt_q == FRAME_MAX);
        pc_d    = w_ppm_rise ? pc_bump(pc_q) : pc_q;
        pos_d   = (w_ppm_rise && (pc_q == PC_NONE)) ? (cnt_q - SUB_W) : pos_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            pos_q       <= '0;
            pc_q        <= PC_NONE;
            out_q       <= '0;
            valid_q     <= 1'b0;
            err_miss_q  <= 1'b0;
            err_multi_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            valid_q <= 1'b0;
            if (w_close) begin
                pc_q <= PC_NONE;
                case (state_q)
                    HUNT: begin
                        state_q <= TRACK;
                    end
                    TRACK: begin
                        case (pc_d)
                            PC_ONE: begin
                                out_q       <= pos_d;
                                valid_q     <= 1'b1;
                                err_miss_q  <= 1'b0;
                                err_multi_q <= 1'b0;
                            end
                            PC_NONE: begin
                                err_miss_q  <= 1'b1;
                                err_multi_q <= 1'b0;
                            end
                            default: begin
                                err_miss_q  <= 1'b0;
                                err_multi_q <= 1'b1;
                            end
                        endcase
                    end
                    default: begin
                        state_q <= HUNT;
                    end
                endcase
            end else begin
                pc_q <= pc_d;
            end
        end
    end

    always_comb begin
        uio_out                = '0;
        uio_out[VALID_BIT]     = valid_q;
        uio_out[ERR_MISS_BIT]  = err_miss_q;
        uio_out[ERR_MULTI_BIT] = err_multi_q;
    end

    assign uo_out   = out_q;
    assign uio_oe   = UIO_OE_MASK;
    assign w_unused = ^{ena, ui_in[7:2], uio_in};

endmodule
`default_nettype wire
